// File: rtl/hex8_disp_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : hex8_disp_arbiter_if
//  Description : Bundle between the three display requesters and the
//                8-digit hex display arbiter.
//                req       - per-requester level request (bit i = requester i)
//                data0..2  - 8-nibble display word of each requester
//                ack       - one-cycle grant pulse, bit i = requester i
//                disp_data - word driven to the hex display driver
//                disp_en   - display enable (1 = digits lit)
//                owner     - current owner index, meaningful with owner_valid
//                owner_valid - high while a requester is being shown
//                Modport master = requester side, slave = arbiter side.
//  Revision    : 1.0  initial release
// ============================================================================
interface hex8_disp_arbiter_if;
    logic [2:0]  req;
    logic [31:0] data0;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [2:0]  ack;
    logic [31:0] disp_data;
    logic        disp_en;
    logic [1:0]  owner;
    logic        owner_valid;

    modport master (
        output req, data0, data1, data2,
        input  ack, disp_data, disp_en, owner, owner_valid
    );

    modport slave (
        input  req, data0, data1, data2,
        output ack, disp_data, disp_en, owner, owner_valid
    );
endinterface : hex8_disp_arbiter_if
`default_nettype wire

// File: rtl/hex8_disp_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : hex8_disp_arbiter
//  Description : Shares one 8-digit hex display between three requesters.
//                A free-running prescaler produces a 1 ms tick; the owner is
//                shown for DWELL_MS ticks, followed by a BLANK_MS tick gap
//                when another requester is waiting. Grants are round-robin.
//  Ports       : clk     - system clock, rising edge
//                reset_n - asynchronous active-low reset
//                bus     - requester/display bundle (slave modport)
//  Revision    : 1.0  initial release
// ============================================================================
module hex8_disp_arbiter #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int DWELL_MS    = 1000,
    parameter int BLANK_MS    = 20
) (
    input  wire                clk,
    input  wire                reset_n,
    hex8_disp_arbiter_if.slave bus
);
    localparam int TICK_DIV = CLK_FREQ_HZ / 1000;
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0] c_presc_last = PW'(TICK_DIV - 1);
    localparam logic [15:0]   c_dwell_last = 16'(DWELL_MS - 1);
    localparam logic [15:0]   c_blank_last = 16'(BLANK_MS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHOW  = 2'd1,
        S_BLANK = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   cnt_q, cnt_d;           // dwell or blank tick count
    logic [1:0]    last_q, last_d;         // most recently granted requester
    logic [2:0]    ack_q, ack_d;
    logic [31:0]   disp_data_q, disp_data_d;
    logic          disp_en_q, disp_en_d;
    logic [1:0]    owner_q, owner_d;
    logic          owner_valid_q, owner_valid_d;

    logic          w_tick;
    logic [1:0]    w_cand1, w_cand2, w_gnt_idx;
    logic          w_other_req;
    logic          w_do_grant;

    function automatic logic [1:0] f_inc3(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    function automatic logic [31:0] f_word(input logic [1:0]  idx,
                                           input logic [31:0] d0,
                                           input logic [31:0] d1,
                                           input logic [31:0] d2);
        case (idx)
            2'd0:    return d0;
            2'd1:    return d1;
            default: return d2;
        endcase
    endfunction

    assign w_tick      = (presc_q == c_presc_last);
    assign w_other_req = |(bus.req & ~(3'b001 << owner_q));

    // Search order last+1, last+2, last. When nothing is requesting the
    // result is unused, so falling back to last is harmless.
    always_comb begin
        w_cand1 = f_inc3(last_q);
        w_cand2 = f_inc3(w_cand1);
        if (bus.req[w_cand1]) begin
            w_gnt_idx = w_cand1;
        end else if (bus.req[w_cand2]) begin
            w_gnt_idx = w_cand2;
        end else begin
            w_gnt_idx = last_q;
        end
    end

    always_comb begin
        state_d       = state_q;
        presc_d       = w_tick ? '0 : presc_q + 1'b1;
        cnt_d         = cnt_q;
        last_d        = last_q;
        ack_d         = 3'b000;
        disp_data_d   = disp_data_q;
        disp_en_d     = disp_en_q;
        owner_d       = owner_q;
        owner_valid_d = owner_valid_q;
        w_do_grant    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                w_do_grant = |bus.req;
            end

            S_SHOW: begin
                // The word follows the owner only while it still requests;
                // after a drop the last shown word is frozen.
                if (bus.req[owner_q]) begin
                    disp_data_d = f_word(owner_q, bus.data0, bus.data1, bus.data2);
                end
                if (w_tick) begin
                    if (cnt_q == c_dwell_last) begin
                        cnt_d = 16'd0;
                        if (w_other_req) begin
                            state_d       = S_BLANK;
                            disp_en_d     = 1'b0;
                            owner_valid_d = 1'b0;
                            disp_data_d   = 32'd0;
                        end else if (!bus.req[owner_q]) begin
                            state_d       = S_IDLE;
                            disp_en_d     = 1'b0;
                            owner_valid_d = 1'b0;
                            disp_data_d   = 32'd0;
                        end
                        // Otherwise the sole requester keeps the display
                        // for another dwell without a new ack.
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end

            S_BLANK: begin
                if (w_tick) begin
                    if (cnt_q == c_blank_last) begin
                        cnt_d = 16'd0;
                        if (|bus.req) begin
                            w_do_grant = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_do_grant) begin
            state_d       = S_SHOW;
            ack_d         = 3'b001 << w_gnt_idx;
            owner_d       = w_gnt_idx;
            owner_valid_d = 1'b1;
            disp_en_d     = 1'b1;
            disp_data_d   = f_word(w_gnt_idx, bus.data0, bus.data1, bus.data2);
            cnt_d         = 16'd0;
            last_d        = w_gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            presc_q       <= '0;
            cnt_q         <= 16'd0;
            last_q        <= 2'd2;
            ack_q         <= 3'b000;
            disp_data_q   <= 32'd0;
            disp_en_q     <= 1'b0;
            owner_q       <= 2'd0;
            owner_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            cnt_q         <= cnt_d;
            last_q        <= last_d;
            ack_q         <= ack_d;
            disp_data_q   <= disp_data_d;
            disp_en_q     <= disp_en_d;
            owner_q       <= owner_d;
            owner_valid_q <= owner_valid_d;
        end
    end

    assign bus.ack         = ack_q;
    assign bus.disp_data   = disp_data_q;
    assign bus.disp_en     = disp_en_q;
    assign bus.owner       = owner_q;
    assign bus.owner_valid = owner_valid_q;

endmodule : hex8_disp_arbiter
`default_nettype wire

// File: tb/tb_hex8_disp_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_hex8_disp_arbiter
//  Description : Self-checking bench for hex8_disp_arbiter. A reference
//                model predicts the outputs of every cycle from tick
//                deadlines and pushes them into a scoreboard queue; a
//                monitor pops and compares on the falling edge. Directed
//                scenarios are followed by randomized requests and data.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hex8_disp_arbiter;
    localparam int CLK_HZ = 10_000;
    localparam int DIV    = CLK_HZ / 1000;
    localparam int DWELL  = 3;
    localparam int BLANK  = 2;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    hex8_disp_arbiter_if bus ();

    hex8_disp_arbiter #(
        .CLK_FREQ_HZ (CLK_HZ),
        .DWELL_MS    (DWELL),
        .BLANK_MS    (BLANK)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks  = 0;
    int n_errors  = 0;
    int ack_seen  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_dark(input string name);
        check({name, "_ack"},         32'(bus.ack),         32'd0);
        check({name, "_disp_data"},   bus.disp_data,        32'd0);
        check({name, "_disp_en"},     32'(bus.disp_en),     32'd0);
        check({name, "_owner"},       32'(bus.owner),       32'd0);
        check({name, "_owner_valid"}, 32'(bus.owner_valid), 32'd0);
    endtask

    // ---------------- reference model ----------------
    typedef enum int {M_IDLE, M_SHOW, M_BLANK} mmode_t;
    typedef struct {
        logic [2:0]  ack;
        logic [31:0] data;
        logic        en;
        logic [1:0]  owner;
        logic        valid;
    } exp_t;

    exp_t   sb_q[$];
    exp_t   m_out;
    mmode_t m_mode     = M_IDLE;
    int     m_c        = 0;   // index of the current clock interval since reset
    int     m_deadline = 0;   // interval index of the expiring tick
    int     m_last     = 2;

    // Tick intervals are those with index % DIV == DIV-1; the n-th tick at
    // or after 'start' ends the period.
    function automatic int period_end(input int start, input int n_ticks);
        return start + (DIV - 1 - (start % DIV)) + DIV * (n_ticks - 1);
    endfunction

    function automatic logic [31:0] word_of(input int i);
        case (i)
            0:       return bus.data0;
            1:       return bus.data1;
            default: return bus.data2;
        endcase
    endfunction

    task automatic go_dark();
        m_out.en    = 1'b0;
        m_out.valid = 1'b0;
        m_out.data  = 32'd0;
    endtask

    task automatic model_step();
        logic [2:0] r;
        int         idx;
        bit         granted;
        r           = bus.req;
        m_out.ack   = 3'b000;
        granted     = 1'b0;
        case (m_mode)
            M_IDLE:  granted = (r != 3'b000);
            M_SHOW: begin
                if (r[m_out.owner]) m_out.data = word_of(int'(m_out.owner));
                if (m_c == m_deadline) begin
                    if ((r & ~(3'b001 << m_out.owner)) != 3'b000) begin
                        m_mode     = M_BLANK;
                        m_deadline = period_end(m_c + 1, BLANK);
                        go_dark();
                    end else if (r[m_out.owner]) begin
                        m_deadline = period_end(m_c + 1, DWELL);
                    end else begin
                        m_mode = M_IDLE;
                        go_dark();
                    end
                end
            end
            default: begin
                if (m_c == m_deadline) begin
                    if (r != 3'b000) granted = 1'b1;
                    else             m_mode  = M_IDLE;
                end
            end
        endcase
        if (granted) begin
            idx = -1;
            for (int k = 1; k <= 3; k++)
                if (idx < 0 && r[(m_last + k) % 3]) idx = (m_last + k) % 3;
            m_mode      = M_SHOW;
            m_last      = idx;
            m_deadline  = period_end(m_c + 1, DWELL);
            m_out.ack   = 3'b001 << idx;
            m_out.owner = 2'(idx);
            m_out.valid = 1'b1;
            m_out.en    = 1'b1;
            m_out.data  = word_of(idx);
        end
        sb_q.push_back(m_out);
        m_c++;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode      = M_IDLE;
            m_c         = 0;
            m_deadline  = 0;
            m_last      = 2;
            m_out.ack   = 3'b000;
            m_out.data  = 32'd0;
            m_out.en    = 1'b0;
            m_out.owner = 2'd0;
            m_out.valid = 1'b0;
            sb_q.delete();
        end else begin
            model_step();
        end
    end

    // ---------------- monitor ----------------
    task automatic monitor_step();
        exp_t e;
        e = sb_q.pop_front();
        check("ack",         32'(bus.ack),         32'(e.ack));
        check("disp_data",   bus.disp_data,        e.data);
        check("disp_en",     32'(bus.disp_en),     32'(e.en));
        check("owner_valid", 32'(bus.owner_valid), 32'(e.valid));
        if (e.valid) check("owner", 32'(bus.owner), 32'(e.owner));
        if (bus.ack != 3'b000) ack_seen++;
    endtask

    always @(negedge clk) begin
        if (reset_n && sb_q.size() > 0) monitor_step();
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_ack(input logic [2:0] exp, input int budget, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            #1;
            if (bus.ack != 3'b000) seen = 1'b1;
        end
        check(name, 32'(bus.ack), 32'(exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int shows[$];
        int blanks[$];
        int owners[$];
        int run;
        int nack;
        int a0;
        int len;
        bit pv;
        bit had_show;
        bit hit;

        bus.req   = 3'b000;
        bus.data0 = $urandom;
        bus.data1 = $urandom;
        bus.data2 = $urandom;
        #3;
        check_dark("reset");
        step(2);
        reset_n = 1'b1;

        // All three requesting: owners rotate 0,1,2,0 with blank gaps.
        bus.req  = 3'b111;
        run      = 0;
        nack     = 0;
        pv       = 1'b0;
        had_show = 1'b0;
        for (int i = 0; i < 300 && nack < 4; i++) begin
            @(posedge clk);
            #1;
            if (bus.owner_valid != pv) begin
                if (pv)            shows.push_back(run);
                else if (had_show) blanks.push_back(run);
                if (bus.owner_valid) had_show = 1'b1;
                run = 0;
                pv  = bus.owner_valid;
            end
            run++;
            if (bus.ack != 3'b000) begin
                nack++;
                owners.push_back(int'(bus.owner));
            end
        end
        check("rr_grants", 32'(nack), 32'd4);
        for (int i = 0; i < owners.size(); i++)
            check("rr_owner_seq", 32'(owners[i]), 32'(i % 3));
        check("rr_show_count", 32'(shows.size()), 32'd3);
        foreach (shows[i])  check("rr_show_len_in_21_30",  32'(shows[i] >= 21 && shows[i] <= 30), 32'd1);
        check("rr_blank_count", 32'(blanks.size()), 32'd3);
        foreach (blanks[i]) check("rr_blank_len_in_11_20", 32'(blanks[i] >= 11 && blanks[i] <= 20), 32'd1);
        bus.req = 3'b000;
        step(40);

        // Single requester holds the display indefinitely with one ack.
        bus.data0 = 32'h01234567;
        a0        = ack_seen;
        bus.req   = 3'b001;
        wait_ack(3'b001, 5, "solo_ack");
        check("solo_disp_data", bus.disp_data, 32'h01234567);
        check("solo_disp_en",   32'(bus.disp_en), 32'd1);
        check("solo_owner",     32'(bus.owner), 32'd0);
        step(80);
        check("solo_single_ack", 32'(ack_seen - a0), 32'd1);

        // Owner data changes are followed one cycle later.
        bus.data0 = 32'hAAAA0000;
        step(3);
        bus.data0 = 32'h0000BBBB;
        #1;
        check("track_old_word", bus.disp_data, 32'hAAAA0000);
        @(posedge clk);
        #1;
        check("track_new_word", bus.disp_data, 32'h0000BBBB);

        // Competitor rises in the very cycle of the expiring tick.
        step(1);
        hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (m_mode == M_SHOW && m_c == m_deadline) begin
                hit = 1'b1;
                break;
            end
            step(1);
        end
        check("expiry_cycle_reached", 32'(hit), 32'd1);
        bus.req = 3'b101;
        wait_ack(3'b100, 30, "blank_then_r2");
        bus.req = 3'b000;
        step(40);

        // Owner drops its request early: dwell runs full length, then idle.
        bus.req = 3'b010;
        wait_ack(3'b010, 5, "drop_ack_r1");
        step(5);
        bus.req = 3'b000;
        len     = 6;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (!bus.owner_valid) break;
            len++;
        end
        check("drop_show_len_in_21_30", 32'(len >= 21 && len <= 30), 32'd1);
        check("drop_idle_disp_en", 32'(bus.disp_en), 32'd0);

        // Reset in the middle of requester 2's show.
        bus.req = 3'b100;
        wait_ack(3'b100, 5, "pre_reset_r2");
        step(8);
        reset_n = 1'b0;
        #1;
        check_dark("reset_mid_show");
        bus.req = 3'b110;
        step(2);
        reset_n = 1'b1;
        wait_ack(3'b010, 5, "post_reset_r1");

        // Randomized requests and data against the model.
        step(1);
        for (int s = 0; s < 150; s++) begin
            len     = $urandom_range(1, 40);
            bus.req = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom);
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 3))
                    0:       bus.data0 = $urandom;
                    1:       bus.data1 = $urandom;
                    2:       bus.data2 = $urandom;
                    default: ;
                endcase
                step(1);
            end
        end
        bus.req = 3'b000;
        step(40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule : tb_hex8_disp_arbiter
`default_nettype wire
